// File: rtl/acia_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : acia_tx_arbiter
// Purpose  : Shares the byte-wide return path to the io controller between
//            the ikbd output fifo and the midi output fifo. Pops one byte at
//            a time from a fifo that holds data, tags it with its source and
//            holds it until the io controller acknowledges it. After each
//            acknowledge, GAP_CYCLES idle cycles let the popped fifo's
//            available flag settle before the next grant.
// Ports    : clk_i              system clock, all state changes on posedge
//            reset_i            asynchronous active-high reset
//            ikbd_available_i   ikbd fifo non-empty
//            ikbd_data_i[7:0]   ikbd fifo head byte
//            ikbd_strobe_o      one-cycle pop pulse to ikbd fifo
//            midi_available_i   midi fifo non-empty
//            midi_data_i[7:0]   midi fifo head byte
//            midi_strobe_o      one-cycle pop pulse to midi fifo
//            out_valid_o        out_data_o/out_src_o hold an unacked byte
//            out_data_o[7:0]    byte handed to the io controller
//            out_src_o          0 = ikbd, 1 = midi
//            out_ack_i          io controller consumed the byte (HOLD only)
//            busy_o             high while in HOLD or GAP
// Parameter: GAP_CYCLES         idle cycles after each ack, legal 1..15
// Macro    : ACIA_ARB_IKBD_PRIO_EN  defined -> ikbd has strict priority on
//            ties; undefined (default) -> round-robin on ties.
// Revision : 1.0  initial release
// ============================================================================
module acia_tx_arbiter #(
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       ikbd_available_i,
   input  logic [7:0] ikbd_data_i,
   output logic       ikbd_strobe_o,
   input  logic       midi_available_i,
   input  logic [7:0] midi_data_i,
   output logic       midi_strobe_o,
   output logic       out_valid_o,
   output logic [7:0] out_data_o,
   output logic       out_src_o,
   input  logic       out_ack_i,
   output logic       busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   state_t     state_q;
   logic [3:0] gap_cnt_q;
   logic       last_src_q;
   logic       ikbd_strobe_q;
   logic       midi_strobe_q;
   logic       out_valid_q;
   logic [7:0] out_data_q;
   logic       out_src_q;
   logic       busy_q;

   // Source chosen if a grant happens this cycle: 1 = midi, 0 = ikbd.
   logic       sel_midi_d;

   always_comb begin
      sel_midi_d = 1'b0;
`ifdef ACIA_ARB_IKBD_PRIO_EN
      // ikbd always wins a tie; last_src_q is tracked but not consulted.
      sel_midi_d = midi_available_i & ~ikbd_available_i;
`else
      // On a tie, grant the source that was not served last.
      sel_midi_d = midi_available_i & (~ikbd_available_i | ~last_src_q);
`endif
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         gap_cnt_q     <= 4'd0;
         last_src_q    <= 1'b1;   // midi, so ikbd wins the first tie
         ikbd_strobe_q <= 1'b0;
         midi_strobe_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 8'h00;
         out_src_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         // Strobes are single-cycle: only the granting edge raises one.
         ikbd_strobe_q <= 1'b0;
         midi_strobe_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ikbd_available_i | midi_available_i) begin
                  out_data_q    <= sel_midi_d ? midi_data_i : ikbd_data_i;
                  out_src_q     <= sel_midi_d;
                  ikbd_strobe_q <= ~sel_midi_d;
                  midi_strobe_q <= sel_midi_d;
                  out_valid_q   <= 1'b1;
                  last_src_q    <= sel_midi_d;
                  busy_q        <= 1'b1;
                  state_q       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // out_data_q/out_src_q intentionally keep their values.
               if (out_ack_i) begin
                  out_valid_q <= 1'b0;
                  gap_cnt_q   <= GAP_LOAD;
                  state_q     <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == 4'd0) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ikbd_strobe_o = ikbd_strobe_q;
   assign midi_strobe_o = midi_strobe_q;
   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign out_src_o     = out_src_q;
   assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: doc/acia_tx_arbiter.md
# acia_tx_arbiter

Shares the single byte-wide return path to the io controller between the ikbd output fifo and the midi output fifo of the ACIA block. Pops one byte at a time from whichever fifo holds data, tags it with its source, and holds it until the io controller acknowledges it. Sits between the two ACIA output fifos and the SPI-side io controller logic, in the CPU clock domain.

## Interface
- GAP_CYCLES, 1, idle cycles after each acknowledge before the next grant; legal range 1..15
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- ikbd_available  in  1  ikbd output fifo non-empty
- ikbd_data  in  8  ikbd output fifo head byte
- ikbd_strobe  out  1  one-cycle pop pulse to ikbd output fifo
- midi_available  in  1  midi output fifo non-empty
- midi_data  in  8  midi output fifo head byte
- midi_strobe  out  1  one-cycle pop pulse to midi output fifo
- out_valid  out  1  out_data/out_src hold a byte not yet acknowledged
- out_data  out  8  byte handed to io controller
- out_src  out  1  source of out_data: 0 = ikbd, 1 = midi
- out_ack  in  1  io controller consumed the byte; sampled only in HOLD
- busy  out  1  high in HOLD and GAP

## Operation
- States: IDLE, HOLD, GAP. Reset state IDLE.
- IDLE: if neither available, stay. Otherwise pick a source (arbitration below); at that edge register out_data <= source data, out_src <= source, the source's strobe <= 1, out_valid <= 1, last_src <= source, state <= HOLD.
- HOLD: strobes forced 0 after the first HOLD cycle. Remain until out_ack = 1; at that edge out_valid <= 0, gap counter <= GAP_CYCLES-1, state <= GAP.
- GAP: counter decrements each cycle; at count 0 go to IDLE. Gap lets the popped fifo's available flag settle; the arbiter never samples available outside IDLE.
- Arbitration (round-robin): only one available -> that one. Both available -> the source not equal to last_src. last_src resets to 1 (midi) so ikbd wins the first tie.
- out_data/out_src hold their last values after acknowledge (not cleared); only out_valid qualifies them.
- out_ack while in IDLE or GAP is ignored; no error state.
- Reset asserted mid-HOLD: byte is lost (already popped); all outputs return to reset values immediately.
- Reset values: ikbd_strobe 0, midi_strobe 0, out_valid 0, out_data 8'h00, out_src 0, busy 0.

## Timing
- Grant latency: available high in an IDLE cycle -> strobe and out_valid high from the next cycle.
- Strobe width exactly 1 cycle; never both strobes high at once.
- out_ack may be high in the first HOLD cycle; HOLD then lasts 1 cycle.
- Minimum byte period with continuous ack: 1 (IDLE) + 1 (HOLD) + GAP_CYCLES cycles = 3 at default.
- busy is registered and equals (state != IDLE).

## Configuration
- ACIA_ARB_IKBD_PRIO_EN defined: strict priority, ikbd always wins when both available; last_src still updated but unused for selection.
- ACIA_ARB_IKBD_PRIO_EN undefined: round-robin as above (default build).

## Test plan
- Reset, ikbd_available=1 with ikbd_data=8'hA5, midi idle, out_ack tied 1 -> ikbd_strobe one-cycle pulse one cycle later, out_valid=1, out_data=8'hA5, out_src=0; out_valid low the next cycle, IDLE again after 1 GAP cycle.
- Both available continuously, ikbd=8'h11, midi=8'h22, ack tied 1 -> grants alternate ikbd, midi, ikbd, ... with out_src 0,1,0,1, one byte every 3 cycles; with ACIA_ARB_IKBD_PRIO_EN defined -> all grants ikbd.
- midi byte 8'h90 granted, out_ack held 0 for 20 cycles -> out_valid stays 1, out_data stays 8'h90, no further strobes; ack pulse -> out_valid 0 next cycle.
- GAP_CYCLES=4, ack tied 1, ikbd always available -> ikbd_strobe pulses exactly every 6 cycles.
- Assert reset during HOLD -> out_valid, strobes, busy drop to 0 asynchronously; after release, next grant occurs normally with ikbd winning tie.
- out_ack pulses while IDLE with no data -> no state change, out_valid stays 0.
